tcm_dual_port_mem: RTL and testbench
====================================

Name: tcm_dual_port_mem

Overview:
- 64 KB tightly-coupled memory for the uriscv core: single storage array, two ports.
- Instruction-fetch port plus data load/store port with byte write enables and tag echo.
- Sits directly between the core's mem_i_* / mem_d_* buses, with no cache in between.
- Also provides a simulation back-door byte-write task so benches can preload a program image.

Parameters:
- MEM_ADDR_W, 16: byte-address width; capacity 2^MEM_ADDR_W bytes, organised as 2^(MEM_ADDR_W-2) 32-bit little-endian words.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous active-high reset
- mem_i_rd_i  in  1  fetch request
- mem_i_flush_i  in  1  fetch flush (no-op)
- mem_i_invalidate_i  in  1  fetch invalidate (no-op)
- mem_i_pc_i  in  32  fetch byte address
- mem_i_accept_o  out  1  fetch request accepted
- mem_i_valid_o  out  1  fetch response valid
- mem_i_error_o  out  1  fetch error
- mem_i_inst_o  out  32  fetched word
- mem_d_addr_i  in  32  data byte address
- mem_d_data_wr_i  in  32  store data
- mem_d_rd_i  in  1  load request
- mem_d_wr_i  in  4  store byte enables; bit n = byte lane n
- mem_d_cacheable_i  in  1  ignored
- mem_d_req_tag_i  in  11  request tag
- mem_d_invalidate_i  in  1  invalidate request (ack only)
- mem_d_writeback_i  in  1  writeback request (ack only)
- mem_d_flush_i  in  1  flush request (ack only)
- mem_d_data_rd_o  out  32  load data
- mem_d_accept_o  out  1  data request accepted
- mem_d_ack_o  out  1  data response valid
- mem_d_error_o  out  1  data error
- mem_d_resp_tag_o  out  11  echoed tag

Behaviour:
- Word index = addr[MEM_ADDR_W-1:2]; upper address bits ignored (aliasing wrap); addr[1:0] ignored.
- Reset (async assert, registered deassert-synchronous release): mem_i_valid_o=0, mem_i_inst_o=0, mem_d_ack_o=0, mem_d_data_rd_o=0, mem_d_resp_tag_o=0. Array contents are NOT reset.
- mem_i_accept_o=1 and mem_d_accept_o=1 constantly, including during reset. mem_i_error_o=0 and mem_d_error_o=0 constantly.
- Fetch: mem_i_rd_i=1 at edge N -> mem_i_valid_o=1 and mem_i_inst_o=word[pc] during cycle N+1.
  - mem_i_valid_o=0 in cycles after edges without mem_i_rd_i.
  - mem_i_inst_o holds its last value when not valid.
  - Back-to-back requests give one response per cycle.
- Data request = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i.
- Request at edge N -> mem_d_ack_o=1 in cycle N+1 with mem_d_resp_tag_o=mem_d_req_tag_i captured at N. One response per request; back-to-back allowed.
- Store: at edge N, each lane n with mem_d_wr_i[n]=1 gets mem_d_data_wr_i[8n+7:8n]; other lanes unchanged.
- Load: mem_d_data_rd_o = word read at edge N (pre-write value if rd and wr in the same cycle).
- Stores and cache-maintenance requests: mem_d_data_rd_o still updates with the word read at N; core ignores it.
- Same-cycle fetch and store to the same word: fetch returns the old (pre-store) value (read-before-write). Store then load to the same word on consecutive cycles: load returns the new value.
- Reset asserted mid-transaction: pending response discarded; no valid/ack after reset release unless a new request arrives.
- Back-door task write(addr, data8): writes byte addr[MEM_ADDR_W-1:0] of the array immediately, no clock needed. Simulation only.

Test Plan:
- Preload bytes 0..3 = 13,00,00,00 via write(); fetch pc=0 -> next cycle mem_i_valid_o=1, mem_i_inst_o=32'h00000013.
- Store addr=0x100, data=0xAABBCCDD, wr=4'hF, tag=5; then load 0x100 tag=6 -> acks carry tags 5 then 6; load data=0xAABBCCDD.
- Store 0x100 data=0x00000011 wr=4'b0001; load 0x100 -> 0xAABBCC11.
- Fetch pc=0x10000 after preloading 0x0 -> returns word 0 (wrap); load 0xFFFC returns last word.
- Same cycle: fetch 0x200 and store 0x200 = 0x12345678 (old value 0) -> inst 0; following fetch of 0x200 -> 0x12345678.
- Assert rst_i while ack pending -> mem_d_ack_o and mem_i_valid_o drop immediately; array data still readable after reset.

Source files
------------

// File: rtl/tcm_dual_port_mem.sv
// tcm_dual_port_mem
//   Tightly-coupled memory for the uriscv core. It holds one array of
//   2^(MEM_ADDR_W-2) little-endian 32-bit words, shared by two ports.
//   The fetch port and the load/store port each return one registered
//   response in the cycle after the request.
//
// Ports
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   mem_i_rd_i, mem_i_pc_i    fetch request and byte address
//   mem_i_flush_i,
//   mem_i_invalidate_i        fetch maintenance requests, no effect here
//   mem_i_accept_o/valid_o/
//   error_o/inst_o            fetch handshake and response
//   mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i (byte enables),
//   mem_d_req_tag_i           load/store request
//   mem_d_cacheable_i         ignored
//   mem_d_invalidate_i,
//   mem_d_writeback_i,
//   mem_d_flush_i             maintenance requests, acknowledged only
//   mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
//   mem_d_resp_tag_o          data handshake and response
//
// The write() task is a simulation back door for preloading program images.
module tcm_dual_port_mem #(
    parameter int unsigned MEM_ADDR_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [31:0] mem_i_inst_o,

    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);

    localparam int unsigned DEPTH = 2 ** (MEM_ADDR_W - 2);

    logic [31:0] mem_q [DEPTH];

    logic [MEM_ADDR_W-3:0] i_idx;
    logic [MEM_ADDR_W-3:0] d_idx;
    logic                  d_req;

    logic        i_valid_q,  i_valid_d;
    logic [31:0] i_inst_q,   i_inst_d;
    logic        d_ack_q,    d_ack_d;
    logic [31:0] d_data_q,   d_data_d;
    logic [10:0] d_tag_q,    d_tag_d;

    // Upper address bits alias onto the array; byte offsets are ignored.
    assign i_idx = mem_i_pc_i[MEM_ADDR_W-1:2];
    assign d_idx = mem_d_addr_i[MEM_ADDR_W-1:2];

    assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i
                 | mem_d_invalidate_i | mem_d_writeback_i;

    logic unused_inputs;
    assign unused_inputs = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                             mem_i_pc_i[31:MEM_ADDR_W], mem_i_pc_i[1:0],
                             mem_d_addr_i[31:MEM_ADDR_W], mem_d_addr_i[1:0]};

    // Storage array. Both ports read the pre-store value of the edge, so a
    // same-edge fetch/load sees old data and the next access sees new data.
    // This block is a plain clocked always because the back-door task below
    // also writes the array.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (mem_d_wr_i[n]) begin
                    mem_q[d_idx][8*n +: 8] <= mem_d_data_wr_i[8*n +: 8];
                end
            end
        end
    end

    always_comb begin
        i_valid_d = mem_i_rd_i;
        i_inst_d  = i_inst_q;
        d_ack_d   = d_req;
        d_data_d  = d_data_q;
        d_tag_d   = d_tag_q;
        if (mem_i_rd_i) begin
            i_inst_d = mem_q[i_idx];
        end
        if (d_req) begin
            d_data_d = mem_q[d_idx];
            d_tag_d  = mem_d_req_tag_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            i_valid_q <= 1'b0;
            i_inst_q  <= '0;
            d_ack_q   <= 1'b0;
            d_data_q  <= '0;
            d_tag_q   <= '0;
        end else begin
            i_valid_q <= i_valid_d;
            i_inst_q  <= i_inst_d;
            d_ack_q   <= d_ack_d;
            d_data_q  <= d_data_d;
            d_tag_q   <= d_tag_d;
        end
    end

    assign mem_i_accept_o   = 1'b1;
    assign mem_i_error_o    = 1'b0;
    assign mem_i_valid_o    = i_valid_q;
    assign mem_i_inst_o     = i_inst_q;
    assign mem_d_accept_o   = 1'b1;
    assign mem_d_error_o    = 1'b0;
    assign mem_d_ack_o      = d_ack_q;
    assign mem_d_data_rd_o  = d_data_q;
    assign mem_d_resp_tag_o = d_tag_q;

    // Simulation back door: writes one byte of the array without a clock.
    // The update lands at the end of the current time step, before any
    // following clock edge can read it.
    task automatic write(input logic [31:0] addr, input logic [7:0] data8);
        mem_q[addr[MEM_ADDR_W-1:2]][8*addr[1:0] +: 8] <= data8;
    endtask

endmodule

// File: tb/tb_tcm_dual_port_mem.sv
module tb_tcm_dual_port_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rd = 1'b0, i_flush = 1'b0, i_inv = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_accept, i_valid, i_error;
    logic [31:0] i_inst;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_rd = 1'b0, d_cacheable = 1'b0;
    logic [3:0]  d_wr = '0;
    logic [10:0] d_tag = '0;
    logic        d_inv = 1'b0, d_wb = 1'b0, d_flush = 1'b0;
    logic [31:0] d_rdata;
    logic        d_accept, d_ack, d_error;
    logic [10:0] d_rtag;

    int errors = 0;
    int checks = 0;

    // Byte-level reference image of the 64 KB memory.
    logic [7:0] model [65536];

    tcm_dual_port_mem #(.MEM_ADDR_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv),
        .mem_i_pc_i(i_pc), .mem_i_accept_o(i_accept), .mem_i_valid_o(i_valid),
        .mem_i_error_o(i_error), .mem_i_inst_o(i_inst),
        .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd),
        .mem_d_wr_i(d_wr), .mem_d_cacheable_i(d_cacheable), .mem_d_req_tag_i(d_tag),
        .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_flush),
        .mem_d_data_rd_o(d_rdata), .mem_d_accept_o(d_accept), .mem_d_ack_o(d_ack),
        .mem_d_error_o(d_error), .mem_d_resp_tag_o(d_rtag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_rd = 0; i_flush = 0; i_inv = 0;
        d_rd = 0; d_wr = '0; d_inv = 0; d_wb = 0; d_flush = 0;
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int unsigned a;
        a = addr % 65536;
        a = a - (a % 4);
        return {model[a+3], model[a+2], model[a+1], model[a]};
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] be);
        int unsigned a;
        a = addr % 65536;
        a = a - (a % 4);
        for (int n = 0; n < 4; n++)
            if (be[n]) model[a+n] = data[8*n +: 8];
    endfunction

    task automatic bd_write(input logic [31:0] addr, input logic [7:0] b);
        dut.write(addr, b);
        model[addr % 65536] = b;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        repeat (2) tick();
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL rst_ivalid got=%b exp=0", i_valid); end
        checks++; if (i_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=0", i_inst); end
        checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", d_ack); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", d_rdata); end
        checks++; if (d_rtag !== 11'h0) begin errors++; $display("FAIL rst_tag got=%h exp=0", d_rtag); end
        checks++; if ({i_accept, d_accept, i_error, d_error} !== 4'b1100) begin
            errors++; $display("FAIL rst_const got=%b exp=1100", {i_accept, d_accept, i_error, d_error}); end
        rst = 0;
        tick();
    endtask

    task automatic test_fetch_preload();
        bd_write(0, 8'h13); bd_write(1, 8'h00); bd_write(2, 8'h00); bd_write(3, 8'h00);
        i_rd = 1; i_pc = 0;
        tick();
        idle();
        checks++; if (i_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got=%b exp=1", i_valid); end
        checks++; if (i_inst !== 32'h00000013) begin errors++; $display("FAIL fetch_inst got=%h exp=00000013", i_inst); end
        tick();
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle_valid got=%b exp=0", i_valid); end
        checks++; if (i_inst !== 32'h00000013) begin errors++; $display("FAIL fetch_hold got=%h exp=00000013", i_inst); end
    endtask

    task automatic test_store_load();
        d_addr = 32'h100; d_wdata = 32'hAABBCCDD; d_wr = 4'hF; d_tag = 5;
        model_store(32'h100, 32'hAABBCCDD, 4'hF);
        tick();
        checks++; if (d_ack !== 1'b1 || d_rtag !== 11'd5) begin
            errors++; $display("FAIL store_ack got=%b/%0d exp=1/5", d_ack, d_rtag); end
        d_wr = '0; d_rd = 1; d_tag = 6;
        tick();
        checks++; if (d_ack !== 1'b1 || d_rtag !== 11'd6) begin
            errors++; $display("FAIL load_ack got=%b/%0d exp=1/6", d_ack, d_rtag); end
        checks++; if (d_rdata !== 32'hAABBCCDD) begin errors++; $display("FAIL load_data got=%h exp=aabbccdd", d_rdata); end
        d_rd = 0; d_wr = 4'b0001; d_wdata = 32'h00000011; d_tag = 7;
        model_store(32'h100, 32'h11, 4'b0001);
        tick();
        d_wr = '0; d_rd = 1; d_tag = 8;
        tick();
        idle();
        checks++; if (d_rdata !== 32'hAABBCC11) begin errors++; $display("FAIL byte_store got=%h exp=aabbcc11", d_rdata); end
        tick();
        checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL ack_idle got=%b exp=0", d_ack); end
    endtask

    task automatic test_wrap();
        bd_write(32'hFFFC, 8'hEF); bd_write(32'hFFFD, 8'hBE);
        bd_write(32'hFFFE, 8'hAD); bd_write(32'hFFFF, 8'hDE);
        i_rd = 1; i_pc = 32'h10000;
        d_rd = 1; d_addr = 32'hFFFC; d_tag = 11'h7FF;
        tick();
        idle();
        checks++; if (i_inst !== 32'h00000013) begin errors++; $display("FAIL wrap_fetch got=%h exp=00000013", i_inst); end
        checks++; if (d_rdata !== 32'hDEADBEEF || d_rtag !== 11'h7FF) begin
            errors++; $display("FAIL last_word got=%h/%h exp=deadbeef/7ff", d_rdata, d_rtag); end
    endtask

    task automatic test_read_before_write();
        for (int k = 0; k < 4; k++) bd_write(32'h200 + k, 8'h00);
        tick();
        i_rd = 1; i_pc = 32'h200;
        d_addr = 32'h200; d_wdata = 32'h12345678; d_wr = 4'hF; d_rd = 1;
        model_store(32'h200, 32'h12345678, 4'hF);
        tick();
        d_wr = '0; d_rd = 0;
        checks++; if (i_inst !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL rbw_old got=%h/%h exp=0/0", i_inst, d_rdata); end
        tick();
        idle();
        checks++; if (i_inst !== 32'h12345678) begin errors++; $display("FAIL rbw_new got=%h exp=12345678", i_inst); end
    endtask

    task automatic test_random();
        logic [31:0] exp_inst, exp_data;
        logic        exp_valid, exp_ack;
        logic [10:0] exp_tag;
        int          err0;
        err0 = errors;
        for (int a = 0; a < 128; a++) bd_write(a, 8'($urandom));
        tick();
        exp_inst = i_inst; exp_data = d_rdata; exp_tag = d_rtag;
        for (int c = 0; c < 300; c++) begin
            i_rd = 1'($urandom);
            i_pc = ($urandom & 32'hFFFF0003) | (($urandom % 32) << 2);
            d_addr = ($urandom & 32'hFFFF0003) | (($urandom % 32) << 2);
            d_wdata = $urandom;
            d_rd = ($urandom % 3) == 0;
            d_wr = ($urandom % 2) ? 4'($urandom) : 4'h0;
            d_flush = ($urandom % 8) == 0;
            d_inv = ($urandom % 8) == 0;
            d_wb = ($urandom % 8) == 0;
            d_tag = 11'($urandom);
            exp_valid = i_rd;
            if (i_rd) exp_inst = model_word(i_pc);
            exp_ack = d_rd | (|d_wr) | d_flush | d_inv | d_wb;
            if (exp_ack) begin exp_data = model_word(d_addr); exp_tag = d_tag; end
            model_store(d_addr, d_wdata, d_wr);
            tick();
            checks++; if (i_valid !== exp_valid || i_inst !== exp_inst) begin
                errors++; $display("FAIL rand_fetch c=%0d got=%b/%h exp=%b/%h", c, i_valid, i_inst, exp_valid, exp_inst); end
            checks++; if (d_ack !== exp_ack || (exp_ack && (d_rdata !== exp_data || d_rtag !== exp_tag))) begin
                errors++; $display("FAIL rand_data c=%0d got=%b/%h/%h exp=%b/%h/%h", c, d_ack, d_rdata, d_rtag, exp_ack, exp_data, exp_tag); end
            if (errors - err0 > 10) break;
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        i_rd = 1; i_pc = 0; d_rd = 1; d_addr = 32'h100; d_tag = 3;
        tick();
        idle();
        checks++; if (d_ack !== 1'b1 || i_valid !== 1'b1) begin
            errors++; $display("FAIL pre_rst got=%b/%b exp=1/1", d_ack, i_valid); end
        rst = 1;
        #1;
        checks++; if (d_ack !== 1'b0 || i_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst got=%b/%b exp=0/0", d_ack, i_valid); end
        tick();
        rst = 0;
        repeat (2) tick();
        checks++; if (d_ack !== 1'b0 || i_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst got=%b/%b exp=0/0", d_ack, i_valid); end
        d_rd = 1; d_addr = 32'h100; i_rd = 1; i_pc = 32'h200;
        tick();
        idle();
        checks++; if (d_rdata !== model_word(32'h100) || i_inst !== model_word(32'h200)) begin
            errors++; $display("FAIL retained got=%h/%h exp=%h/%h", d_rdata, i_inst, model_word(32'h100), model_word(32'h200)); end
    endtask

    initial begin
        test_reset();
        test_fetch_preload();
        test_store_load();
        test_wrap();
        test_read_before_write();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
